// File: rtl/cskip_sub_pipe_pkg.sv
// Shared slice geometry for the carry-skip adder/subtractor family.
// Both families derive block count and the width check from here so slices line up.
package cskip_sub_pipe_pkg;

   localparam int unsigned CskipWidthDefault = 12;
   localparam int unsigned CskipBlockDefault = 4;

   function automatic int unsigned cskip_nblocks(input int unsigned width,
                                                 input int unsigned block);
      return width / block;
   endfunction

   function automatic bit cskip_geom_ok(input int unsigned width, input int unsigned block);
      return (block != 0) && (width != 0) && ((width % block) == 0);
   endfunction

endpackage

// File: rtl/cskip_sub_block.sv
// One BLOCK-wide slice of the subtractor: a + ~b + cin with ripple carry-out and
// the all-propagate flag used by the skip mux in the pipeline.
module cskip_sub_block
   import cskip_sub_pipe_pkg::*;
#(
   parameter int unsigned BLOCK = CskipBlockDefault
) (
   input  logic [BLOCK-1:0] a_i,
   input  logic [BLOCK-1:0] b_i,
   input  logic             cin_i,
   output logic [BLOCK-1:0] d_o,
   output logic             cout_o,
   output logic             p_o
);

   logic [BLOCK:0] sum;

   assign sum          = {1'b0, a_i} + {1'b0, ~b_i} + {{BLOCK{1'b0}}, cin_i};
   assign {cout_o, d_o} = sum;
   assign p_o          = &(a_i ^ ~b_i);

endmodule

// File: rtl/cskip_sub_pipe.sv
// Pipelined carry-skip subtractor: one slice resolved per stage, valid/ready on both sides.
// The last stage register is the output register; o_ready ripples back from i_ready.
module cskip_sub_pipe
   import cskip_sub_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = CskipWidthDefault,
   parameter int unsigned BLOCK = CskipBlockDefault
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_sub_term1,
   input  logic [WIDTH-1:0] i_sub_term2,
   input  logic             i_bin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow,
   output logic             o_ovf
);

   localparam int unsigned NSTAGES = cskip_nblocks(WIDTH, BLOCK);

   if (!cskip_geom_ok(WIDTH, BLOCK)) begin : g_geom_err
      $error("cskip_sub_pipe: WIDTH must be a non-zero multiple of BLOCK");
   end

   logic [NSTAGES-1:0] valid_q;
   logic [NSTAGES-1:0] bw_q;
   logic [WIDTH-1:0]   a_q [NSTAGES];
   logic [WIDTH-1:0]   b_q [NSTAGES];
   logic [WIDTH-1:0]   d_q [NSTAGES];
   logic               ovf_q;

   logic [NSTAGES-1:0] en;
   logic [NSTAGES-1:0] vin;
   logic [NSTAGES-1:0] c_in;
   logic [NSTAGES-1:0] bw_nx;
   logic [WIDTH-1:0]   a_in [NSTAGES];
   logic [WIDTH-1:0]   b_in [NSTAGES];
   logic [WIDTH-1:0]   d_in [NSTAGES];
   logic [WIDTH-1:0]   d_nx [NSTAGES];
   logic               ovf_nx;

   for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      logic [BLOCK-1:0] slice;
      logic             cout;
      logic             p;

      if (k == 0) begin : g_first
         assign vin[k]  = i_valid;
         assign a_in[k] = i_sub_term1;
         assign b_in[k] = i_sub_term2;
         assign d_in[k] = '0;
         assign c_in[k] = ~i_bin;
      end else begin : g_next
         assign vin[k]  = valid_q[k-1];
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign d_in[k] = d_q[k-1];
         assign c_in[k] = ~bw_q[k-1];
      end

      // A stage may load when empty or when its occupant leaves this same cycle.
      if (k == NSTAGES - 1) begin : g_last
         assign en[k] = ~valid_q[k] | i_ready;
      end else begin : g_mid
         assign en[k] = ~valid_q[k] | en[k+1];
      end

      cskip_sub_block #(
         .BLOCK (BLOCK)
      ) u_blk (
         .a_i    (a_in[k][k*BLOCK +: BLOCK]),
         .b_i    (b_in[k][k*BLOCK +: BLOCK]),
         .cin_i  (c_in[k]),
         .d_o    (slice),
         .cout_o (cout),
         .p_o    (p)
      );

      assign bw_nx[k] = ~(p ? c_in[k] : cout);
      // Upper diff bits are always zero upstream, so OR-ing the new slice in is enough.
      assign d_nx[k]  = d_in[k] | (WIDTH'(slice) << (k * BLOCK));
   end

   assign ovf_nx = (a_in[NSTAGES-1][WIDTH-1] ^ b_in[NSTAGES-1][WIDTH-1]) &
                   (d_nx[NSTAGES-1][WIDTH-1] ^ a_in[NSTAGES-1][WIDTH-1]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         bw_q    <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < NSTAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            d_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NSTAGES; k++) begin
            if (en[k]) begin
               valid_q[k] <= vin[k];
               // Data only moves with a valid item so outputs hold while idle.
               if (vin[k]) begin
                  a_q[k]  <= a_in[k];
                  b_q[k]  <= b_in[k];
                  d_q[k]  <= d_nx[k];
                  bw_q[k] <= bw_nx[k];
               end
            end
         end
         if (en[NSTAGES-1] && vin[NSTAGES-1]) begin
            ovf_q <= ovf_nx;
         end
      end
   end

   assign o_ready  = en[0];
   assign o_valid  = valid_q[NSTAGES-1];
   assign o_diff   = d_q[NSTAGES-1];
   assign o_borrow = bw_q[NSTAGES-1];
   assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_cskip_sub_pipe.sv
// Bench for cskip_sub_pipe: directed corner cases plus random handshake traffic
// scored against an integer-arithmetic reference model.
module tb_cskip_sub_pipe;

   localparam int unsigned WIDTH = 12;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [WIDTH-1:0] i_sub_term1 = '0;
   logic [WIDTH-1:0] i_sub_term2 = '0;
   logic             i_bin = 1'b0;
   logic             o_valid;
   logic             i_ready = 1'b0;
   logic [WIDTH-1:0] o_diff;
   logic             o_borrow;
   logic             o_ovf;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             b;
      logic             o;
   } exp_t;

   exp_t exp_q[$];
   int   pop_idx[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   step_idx = 0;
   int   n_acc = 0;

   logic             s_valid;
   logic             s_ready;
   logic             s_borrow;
   logic             s_ovf;
   logic [WIDTH-1:0] s_diff;

   always #5 clk = ~clk;

   cskip_sub_pipe #(
      .WIDTH (WIDTH),
      .BLOCK (4)
   ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_sub_term1 (i_sub_term1),
      .i_sub_term2 (i_sub_term2),
      .i_bin       (i_bin),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_diff      (o_diff),
      .o_borrow    (o_borrow),
      .o_ovf       (o_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: unsigned/signed integer arithmetic on the operands.
   function automatic exp_t model(input int a, input int b, input int bin);
      exp_t e;
      int   diff;
      int   sa;
      int   sb;
      int   t;
      diff = a - b - bin;
      e.d  = diff[WIDTH-1:0];
      e.b  = (a < b + bin);
      sa   = (a >= 2048) ? a - 4096 : a;
      sb   = (b >= 2048) ? b - 4096 : b;
      t    = sa - sb - bin;
      e.o  = (t < -2048) || (t > 2047);
      return e;
   endfunction

   task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, input logic rdy);
      exp_t e;
      @(negedge clk);
      i_valid     = v;
      i_sub_term1 = a;
      i_sub_term2 = b;
      i_bin       = bin;
      i_ready     = rdy;
      #1;
      s_valid  = o_valid;
      s_ready  = o_ready;
      s_diff   = o_diff;
      s_borrow = o_borrow;
      s_ovf    = o_ovf;
      if (v && o_ready) begin
         exp_q.push_back(model(int'(a), int'(b), int'(bin)));
         n_acc++;
      end
      if (o_valid && rdy) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_diff", 32'(o_diff), 32'(e.d));
            check("sb_borrow", 32'(o_borrow), 32'(e.b));
            check("sb_ovf", 32'(o_ovf), 32'(e.o));
            pop_idx.push_back(step_idx);
         end
      end
      step_idx++;
   endtask

   task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic bin, input logic [WIDTH-1:0] ed, input logic eb,
                           input logic eo);
      step(1'b1, a, b, bin, 1'b1);
      check("dir_accept", 32'(s_ready), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1);
         check("dir_latency", 32'(s_valid), 32'(i == 3));
      end
      check("dir_diff", 32'(s_diff), 32'(ed));
      check("dir_borrow", 32'(s_borrow), 32'(eb));
      check("dir_ovf", 32'(s_ovf), 32'(eo));
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      int               n_stale;

      #12;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_diff", 32'(o_diff), 32'd0);
      check("rst_borrow", 32'(o_borrow), 32'd0);
      check("rst_ovf", 32'(o_ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      directed(12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1);
      directed(12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0);
      directed(12'h5A5, 12'h5A5, 1'b1, 12'hFFF, 1'b1, 1'b0);

      // Back-to-back issue with free-flowing output.
      pop_idx.delete();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      end
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
      check("b2b_count", 32'(pop_idx.size()), 32'd8);
      for (int i = 1; i < pop_idx.size(); i++) begin
         check("b2b_gap", 32'(pop_idx[i] - pop_idx[i-1]), 32'd1);
      end

      // Stalled output with continuous offers: only the three stages fill.
      n_acc = 0;
      held  = '0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
         if (i == 3) held = s_diff;
      end
      check("stall_accepts", 32'(n_acc), 32'd3);
      check("stall_oready", 32'(s_ready), 32'd0);
      check("stall_ovalid", 32'(s_valid), 32'd1);
      check("stall_hold", 32'(s_diff), 32'(held));
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
      check("stall_drained", 32'(exp_q.size()), 32'd0);

      // Reset with two items in flight.
      step(1'b1, 12'h123, 12'h001, 1'b0, 1'b0);
      step(1'b1, 12'h456, 12'h001, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      check("pre_rst_valid", 32'(s_valid), 32'd1);
      check("pre_rst_inflight", 32'(exp_q.size()), 32'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_diff", 32'(o_diff), 32'd0);
      check("mid_rst_borrow", 32'(o_borrow), 32'd0);
      check("mid_rst_ovf", 32'(o_ovf), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      n_stale = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1);
         n_stale += int'(s_valid);
      end
      check("rst_no_stale", 32'(n_stale), 32'd0);

      // Random traffic with random backpressure.
      for (int i = 0; i < 10000; i++) begin
         step(1'(($urandom % 4) != 0), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
              1'(($urandom % 4) != 0));
      end
      for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
